// File: rtl/stage_control_fsm_if.sv
// stage_control_fsm_if: decode inputs and datapath control strobes of the JALA stage-5 control unit
interface stage_control_fsm_if #(parameter int INSTR_CNT_W = 16);
  logic [3:0] Opcode;
  logic Zero;
  logic PCWrite, PCSource, PCAdd;
  logic MSPWrite, MSPPop, RSPWrite, RSPPop;
  logic IRWrite, ValAWrite, ValBWrite;
  logic MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0] MemDst1, MemDst2;
  logic [2:0] MemData, ALUOp;
  logic IllegalOp, Halted;
  logic [INSTR_CNT_W-1:0] InstrCount;
  modport master (
    input Opcode, Zero,
    output PCWrite, PCSource, PCAdd, MSPWrite, MSPPop, RSPWrite, RSPPop,
    output IRWrite, ValAWrite, ValBWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
    output MemDst1, MemDst2, MemData, ALUOp, IllegalOp, Halted, InstrCount
  );
  modport slave (
    output Opcode, Zero,
    input PCWrite, PCSource, PCAdd, MSPWrite, MSPPop, RSPWrite, RSPPop,
    input IRWrite, ValAWrite, ValBWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
    input MemDst1, MemDst2, MemData, ALUOp, IllegalOp, Halted, InstrCount
  );
endinterface

// File: rtl/stage_control_fsm.sv
// stage_control_fsm: multicycle fetch/decode/exec/mem/wb sequencer with retired-instruction counter
module stage_control_fsm #(
  parameter int INSTR_CNT_W = 16
) (
  input logic CLK,
  input logic RST_N,
  stage_control_fsm_if.master bus
);
  typedef enum logic [2:0] {INIT, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, nextState;
  logic [INSTR_CNT_W-1:0] instrCount;
  logic isAlu, retire;
  assign isAlu = bus.Opcode inside {[4'd1:4'd4]};
  assign retire = (state inside {EXEC, MEM, WB}) && (nextState inside {FETCH, HALT});
  assign bus.InstrCount = instrCount;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= INIT;
      instrCount <= '0;
    end else begin
      state <= nextState;
      if (retire) instrCount <= instrCount + INSTR_CNT_W'(1);
    end
  always_comb begin
    nextState = state;
    bus.PCWrite = 1'b0;
    bus.PCSource = 1'b0;
    bus.PCAdd = 1'b0;
    bus.MSPWrite = 1'b0;
    bus.MSPPop = 1'b0;
    bus.RSPWrite = 1'b0;
    bus.RSPPop = 1'b0;
    bus.IRWrite = 1'b0;
    bus.ValAWrite = 1'b0;
    bus.ValBWrite = 1'b0;
    bus.MemRead1 = 1'b0;
    bus.MemRead2 = 1'b0;
    bus.MemWrite1 = 1'b0;
    bus.MemWrite2 = 1'b0;
    bus.MemDst1 = 2'b00;
    bus.MemDst2 = 2'b00;
    bus.MemData = 3'b000;
    bus.ALUOp = 3'd0;
    bus.IllegalOp = 1'b0;
    bus.Halted = 1'b0;
    case (state)
      INIT: nextState = FETCH;
      FETCH: begin
        bus.MemRead1 = 1'b1;
        bus.MemRead2 = 1'b1;
        bus.MemDst2 = 2'b01;
        bus.PCWrite = 1'b1;
        nextState = DECODE;
      end
      DECODE: begin
        bus.IRWrite = 1'b1;
        bus.ValAWrite = 1'b1;
        bus.ValBWrite = 1'b1;
        nextState = EXEC;
      end
      EXEC: begin
        nextState = FETCH;
        case (bus.Opcode)
          4'h1, 4'h2, 4'h3, 4'h4: begin
            bus.ALUOp = 3'(bus.Opcode - 4'd1);
            bus.MSPWrite = 1'b1;
            bus.MSPPop = 1'b1;
            nextState = MEM;
          end
          4'h5: begin
            bus.MSPWrite = 1'b1;
            nextState = MEM;
          end
          4'h6: begin
            bus.MSPWrite = 1'b1;
            bus.MSPPop = 1'b1;
          end
          4'h7: begin
            bus.PCWrite = 1'b1;
            bus.PCAdd = 1'b1;
          end
          4'h8: begin
            bus.PCWrite = bus.Zero;
            bus.PCAdd = bus.Zero;
          end
          4'h9: begin
            bus.RSPWrite = 1'b1;
            nextState = MEM;
          end
          4'hA: begin
            bus.MemRead2 = 1'b1;
            bus.MemDst2 = 2'b10;
            bus.RSPWrite = 1'b1;
            bus.RSPPop = 1'b1;
            nextState = MEM;
          end
          4'hB, 4'hC, 4'hD, 4'hE: bus.IllegalOp = 1'b1;
          4'hF: nextState = HALT;
          default: ;
        endcase
      end
      MEM: begin
        nextState = FETCH;
        if (isAlu) begin
          bus.ALUOp = 3'(bus.Opcode - 4'd1);
          bus.MemWrite1 = 1'b1;
          bus.MemDst1 = 2'b01;
        end
        case (bus.Opcode)
          4'h5: begin
            bus.MemWrite1 = 1'b1;
            bus.MemDst1 = 2'b01;
            bus.MemData = 3'b001;
          end
          4'h9: begin
            bus.MemWrite2 = 1'b1;
            bus.MemDst2 = 2'b10;
            bus.MemData = 3'b010;
            bus.PCWrite = 1'b1;
            bus.PCAdd = 1'b1;
          end
          4'hA: begin
            bus.ValBWrite = 1'b1;
            nextState = WB;
          end
          default: ;
        endcase
      end
      WB: begin
        bus.PCWrite = 1'b1;
        bus.PCSource = 1'b1;
        nextState = FETCH;
      end
      HALT: bus.Halted = 1'b1;
      default: nextState = INIT;
    endcase
  end
endmodule

// File: doc/stage_control_fsm.md
# stage_control_fsm

Multicycle control unit for the JALA stack CPU datapath (stage 5). It sequences the fetch, decode, execute, memory and write-back cycles and drives every datapath enable: PC, MSP, RSP, IR, ValA/ValB and both memory ports. It decodes `IR[15:12]` and the datapath zero flag, and keeps a retired-instruction counter for debug and benches.

## Interface
Parameters:
- `INSTR_CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `Opcode`  in  4  `IROut[15:12]`.
- `Zero`  in  1  high when `ValAOut == 0`.
- `PCWrite`, `PCSource`, `PCAdd`  out  1 each  PC control.
  - `PCSource` 0 selects the adder; 1 selects `ValBOut`.
  - `PCAdd` 0 adds 2; 1 adds `SignExtOut`.
- `MSPWrite`, `MSPPop`, `RSPWrite`, `RSPPop`  out  1 each  stack pointer control.
  - Write with Pop=0 is a push (decrement).
  - Write with Pop=1 is a pop (increment).
- `IRWrite`, `ValAWrite`, `ValBWrite`  out  1 each  register loads.
- `MemRead1`, `MemRead2`, `MemWrite1`, `MemWrite2`  out  1 each  memory port strobes.
- `MemDst1`, `MemDst2`  out  2 each  address select: 00 PC, 01 MSP, 10 RSP, 11 ResOut.
- `MemData`  out  3  write-data select: 000 ResOut, 001 SignExtOut, 010 PCOut, 011 ZeroExtOut.
- `ALUOp`  out  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR.
- `IllegalOp`  out  1  one-cycle pulse on an undefined opcode.
- `Halted`  out  1  high in HALT.
- `InstrCount`  out  `INSTR_CNT_W`  number of retired instructions.

## Operation
States: INIT, FETCH, DECODE, EXEC, MEM, WB, HALT.

- **Reset:** `RST_N` low forces INIT immediately, mid-instruction included. In INIT every output is 0 and `InstrCount` is 0. The first edge with `RST_N` high moves to FETCH.
- **Outputs:** all control outputs are combinational from the current state and `Opcode`. Any strobe not listed for a state is 0.
- **FETCH:**
  - `MemRead1=1`, `MemDst1=00`.
  - `MemRead2=1`, `MemDst2=01`.
  - `PCWrite=1`, `PCSource=0`, `PCAdd=0`.
  - Next state: DECODE.
- **DECODE:** `IRWrite=1`, `ValAWrite=1`, `ValBWrite=1`. Next state: EXEC. `Opcode` is valid from EXEC onward.
- **EXEC**, by opcode:
  - 0 NOP: no strobes. Next: FETCH.
  - 1–4 ALU (ADD, SUB, AND, OR): `ALUOp=Opcode-1`, `MSPWrite=1`, `MSPPop=1`. Next: MEM.
  - 5 PUSHI: `MSPWrite=1`, `MSPPop=0`. Next: MEM.
  - 6 POP: `MSPWrite=1`, `MSPPop=1`. Next: FETCH.
  - 7 JMP: `PCWrite=1`, `PCAdd=1`, `PCSource=0`. Next: FETCH.
  - 8 BRZ: same strobes as JMP, gated by `Zero`. Next: FETCH.
  - 9 CALL: `RSPWrite=1`, `RSPPop=0`. Next: MEM.
  - A RET: `MemRead2=1`, `MemDst2=10`, `RSPWrite=1`, `RSPPop=1`. Next: MEM.
  - B–E: treated as NOP, with `IllegalOp=1` for that cycle. Next: FETCH.
  - F HALT: no strobes. Next: HALT.
- **MEM:**
  - ALU: `MemWrite1=1`, `MemDst1=01`, `MemData=000`, `ALUOp` held. Next: FETCH.
  - PUSHI: `MemWrite1=1`, `MemDst1=01`, `MemData=001`. Next: FETCH.
  - CALL: `MemWrite2=1`, `MemDst2=10`, `MemData=010`, plus `PCWrite=1`, `PCAdd=1`. Next: FETCH.
  - RET: `ValBWrite=1`. Next: WB.
- **WB (RET only):** `PCWrite=1`, `PCSource=1`. Next: FETCH.
- **HALT:** `Halted=1`, all strobes 0. Stays in HALT until `RST_N` is asserted.
- **InstrCount:**
  - Increments by 1 on every transition into FETCH from EXEC, MEM or WB.
  - Also increments on the EXEC→HALT transition.
  - Wraps from all-ones to 0 with no flag.

## Timing
- Cycles per instruction:
  - NOP, POP, JMP, BRZ (taken or not), illegal opcodes: 3.
  - ALU, PUSHI, CALL: 4.
  - RET: 5.
  - HALT: 3, then terminal.
- Strobes are valid from just after the state-change edge. They take effect at the next rising edge.
- `Opcode` and `Zero` are sampled combinationally only in EXEC, MEM and WB. Changes to them in FETCH or DECODE have no effect.
- `IllegalOp` is exactly one cycle wide.
- `Halted` rises on the edge that enters HALT.
- Asynchronous reset mid-MEM or mid-WB aborts the write: all strobes go to 0 at `RST_N` fall, with no clock edge required.

## Test plan
- **Reset and fetch:** hold `RST_N` low for 3 cycles, then release.
  - During reset: all outputs 0, `InstrCount=0`.
  - First edge after release: INIT→FETCH, with `MemRead1=MemRead2=PCWrite=1`, `MemDst2=01`.
  - Next cycle: `IRWrite=ValAWrite=ValBWrite=1`.
- **ALU instruction:** `Opcode=2` (SUB).
  - EXEC: `ALUOp=1`, `MSPWrite=1`, `MSPPop=1`.
  - MEM: `MemWrite1=1`, `MemDst1=01`, `MemData=000`.
  - Back in FETCH after 4 cycles; `InstrCount` goes 0→1.
- **BRZ:** run `Opcode=8` twice.
  - `Zero=1`: EXEC shows `PCWrite=1`, `PCAdd=1`.
  - `Zero=0`: EXEC shows `PCWrite=0`.
  - Both take 3 cycles.
- **CALL then RET:**
  - CALL MEM: `MemWrite2=1`, `MemDst2=10`, `MemData=010`, `PCWrite=1`, `PCAdd=1`.
  - RET sequence: EXEC (RSP pop + read), MEM (`ValBWrite=1`), WB (`PCWrite=1`, `PCSource=1`). Total 5 cycles.
- **Illegal opcode and HALT:**
  - `Opcode=C`: `IllegalOp` pulses exactly 1 cycle.
  - `Opcode=F`: `Halted=1`, and 10 further edges leave all strobes at 0.
  - Asserting `RST_N` low then returns to INIT.
- **Wrap and mid-op reset:**
  - With `INSTR_CNT_W=4`, 16 NOPs: `InstrCount` wraps 15→0.
  - Pull `RST_N` low mid-MEM of a PUSHI: `MemWrite1` drops to 0 before the next edge.
